// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath-facing bus of the multicycle MIPS control unit.
// master: the controller (samples opcode/zero/mem_ready, drives the control lines).
// slave:  the datapath (drives opcode/zero/mem_ready, consumes the control lines).
interface mips_multicycle_ctrl_if;
    // Datapath status into the controller
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    // Control lines out of the controller
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS32 datapath.
// Sequences lw/sw/R-type/beq/addi/j over 3-5 states, drives the datapath control lines,
// flags undefined opcodes and counts retired instructions.
// Optional build macro MC_CTRL_MEMWAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready=1.
module mips_multicycle_ctrl #(
    parameter int unsigned INSTR_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]             state,
    output logic                   illegal_op,
    output logic [INSTR_CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeq     = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StRsvd12  = 4'd12,
        StRsvd13  = 4'd13,
        StRsvd14  = 4'd14,
        StRsvd15  = 4'd15
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    state_e                 state_q, state_d;
    logic                   illegal_q, illegal_d;
    logic [INSTR_CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic       mem_done;
    logic       retire;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_done = bus.mem_ready;
`else
    // Zero-wait memory: every memory state completes in one cycle.
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_done = 1'b1;
`endif

    // Next-state, Moore control decode, illegal-opcode flag and retire detection
    always_comb begin
        state_d    = state_q;
        illegal_d  = 1'b0;
        retire     = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;

        case (state_q)
            StFetch: begin
                // IR load and PC+4 only on the cycle the fetch actually completes
                ir_write  = mem_done;
                pc_write  = mem_done;
                alu_src_b = 2'b01;
                if (mem_done) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeq;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord = 1'b1;
                if (mem_done) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = StFetch;
                retire     = 1'b1;
            end
            StMemWr: begin
                // Strobe held through the whole wait
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_done) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StRtypeEx: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StRtypeWb;
            end
            StRtypeWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = StFetch;
                retire    = 1'b1;
            end
            StBeq: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                state_d   = StFetch;
                retire    = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
                retire    = 1'b1;
            end
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = StFetch;
                retire   = 1'b1;
            end
            default: begin
                // Unused encodings recover to FETCH and report as illegal
                state_d   = StFetch;
                illegal_d = 1'b1;
            end
        endcase

        instr_cnt_d = retire ? instr_cnt_q + INSTR_CNT_W'(1) : instr_cnt_q;
    end

    // State, illegal flag and retire counter; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            illegal_q   <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Output drive; everything forced low while reset is held
    always_comb begin
        bus.pc_en      = rst_n & (pc_write | (branch & bus.zero));
        bus.iord       = rst_n & iord;
        bus.mem_write  = rst_n & mem_write;
        bus.ir_write   = rst_n & ir_write;
        bus.reg_dst    = rst_n & reg_dst;
        bus.mem_to_reg = rst_n & mem_to_reg;
        bus.reg_write  = rst_n & reg_write;
        bus.alu_src_a  = rst_n & alu_src_a;
        bus.alu_src_b  = rst_n ? alu_src_b : 2'b00;
        bus.pc_src     = rst_n ? pc_src : 2'b00;
        bus.alu_op     = rst_n ? alu_op : 2'b00;
        state          = rst_n ? 4'(state_q) : 4'd0;
        illegal_op     = rst_n & illegal_q;
        instr_cnt      = rst_n ? instr_cnt_q : '0;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl.
// The reference model expands each opcode into its expected state walk and looks up the
// documented control values per state; counter width 4 exercises the wrap.
module tb_mips_multicycle_ctrl;

    localparam int unsigned CntW = 4;
`ifdef MC_CTRL_MEMWAIT_EN
    localparam bit MemWait = 1'b1;
`else
    localparam bit MemWait = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [3:0]      state;
    logic            illegal_op;
    logic [CntW-1:0] instr_cnt;

    mips_multicycle_ctrl_if bus_if ();

    mips_multicycle_ctrl #(
        .INSTR_CNT_W (CntW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .state      (state),
        .illegal_op (illegal_op),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int cnt_exp      = 0;
    bit pend_illegal = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
    //  alu_src_b[1:0], pc_src[1:0], alu_op[1:0]}
    function automatic logic [12:0] dut_ctrl();
        return {bus_if.iord, bus_if.mem_write, bus_if.ir_write, bus_if.reg_dst,
                bus_if.mem_to_reg, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
                bus_if.pc_src, bus_if.alu_op};
    endfunction

    // Documented control table; returns {pc_write, branch, ctrl[12:0]}
    function automatic logic [14:0] exp_ctrl(input int st, input bit rdy);
        logic iord, mw, irw, rd, m2r, rw, asa, pcw, br;
        logic [1:0] asb, pcs, aop;
        {iord, mw, irw, rd, m2r, rw, asa, pcw, br} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            0:  begin irw = rdy; pcw = rdy; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; br = 1'b1; pcs = 2'b01; end
            9:  begin asa = 1'b1; asb = 2'b10; end
            10: rw = 1'b1;
            11: begin pcs = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {pcw, br, iord, mw, irw, rd, m2r, rw, asa, asb, pcs, aop};
    endfunction

    // Expected state walk of one instruction; empty tail after DECODE means illegal
    task automatic build_seq(input logic [5:0] op, output int seq[$], output bit legal);
        seq = {0, 1};
        legal = 1'b1;
        case (op)
            6'b100011: seq = {seq, 2, 3, 4};
            6'b101011: seq = {seq, 2, 5};
            6'b000000: seq = {seq, 6, 7};
            6'b000100: seq = {seq, 8};
            6'b001000: seq = {seq, 9, 10};
            6'b000010: seq = {seq, 11};
            default:   legal = 1'b0;
        endcase
    endtask

    // Reset held for one cycle: every output must be low
    task automatic reset_cycle();
        @(negedge clk);
        rst_n             = 1'b0;
        bus_if.opcode     = 6'($urandom);
        bus_if.zero       = 1'($urandom);
        bus_if.mem_ready  = 1'($urandom);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_ctrl", 32'(dut_ctrl()), 32'd0);
        check_eq("rst_pc_en", 32'(bus_if.pc_en), 32'd0);
        check_eq("rst_illegal", 32'(illegal_op), 32'd0);
        check_eq("rst_cnt", 32'(instr_cnt), 32'd0);
        @(posedge clk);
        cnt_exp      = 0;
        pend_illegal = 1'b0;
    endtask

    // Run one instruction; abort_at >= 0 asserts reset in that step of the walk
    task automatic run_instr(input logic [5:0] op, input int abort_at);
        int seq[$];
        bit legal;
        build_seq(op, seq, legal);
        for (int idx = 0; idx < seq.size(); idx++) begin
            int st    = seq[idx];
            int waits = 0;
            if (idx == abort_at) begin
                reset_cycle();
                return;
            end
            if (MemWait && (st == 0 || st == 3 || st == 5)) begin
                waits = (st == 5 && $urandom_range(0, 2) == 0) ? 3 : $urandom_range(0, 3);
            end
            for (int w = 0; w <= waits; w++) begin
                logic [14:0] e;
                bit rdy;
                @(negedge clk);
                rst_n            = 1'b1;
                bus_if.opcode    = op;
                bus_if.zero      = 1'($urandom);
                rdy              = MemWait ? (w == waits) : 1'($urandom);
                bus_if.mem_ready = rdy;
                #1;
                e = exp_ctrl(st, MemWait ? rdy : 1'b1);
                check_eq($sformatf("state_op%02h_%0d", op, idx), 32'(state), 32'(st));
                check_eq($sformatf("ctrl_st%0d", st), 32'(dut_ctrl()), 32'(e[12:0]));
                check_eq($sformatf("pc_en_st%0d", st), 32'(bus_if.pc_en),
                         32'(e[14] | (e[13] & bus_if.zero)));
                check_eq($sformatf("illegal_st%0d", st), 32'(illegal_op),
                         32'(pend_illegal && idx == 0 && w == 0));
                check_eq("instr_cnt", 32'(instr_cnt), 32'(cnt_exp));
                @(posedge clk);
            end
        end
        if (legal) begin
            cnt_exp = (cnt_exp + 1) % (1 << CntW);
        end
        pend_illegal = !legal;
    endtask

    function automatic logic [5:0] pick_opcode();
        logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b001000, 6'b000010};
        int r = $urandom_range(0, 8);
        if (r < 6) return ops[r];
        return 6'($urandom);
    endfunction

    initial begin
        rst_n            = 1'b0;
        bus_if.opcode    = '0;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b0;

        reset_cycle();
        reset_cycle();

        // Directed: lw, R-type, beq taken/not-taken, undefined opcode, reset mid-lw
        run_instr(6'b100011, -1);
        run_instr(6'b000000, -1);
        run_instr(6'b000100, -1);
        run_instr(6'b111111, -1);
        run_instr(6'b001000, -1);
        run_instr(6'b100011, 3);
        run_instr(6'b101011, -1);
        run_instr(6'b000010, -1);

        // Random instruction stream; enough retires to wrap the 4-bit counter
        for (int i = 0; i < 120; i++) begin
            run_instr(pick_opcode(), ($urandom_range(0, 40) == 0) ? 2 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
